calc_core: RTL and testbench

CALC_CORE -- requirements
Module: calc_core

---
 rtl/calc_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_calc_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/calc_core.sv
// calc_core: ASCII expression calculator "A op B =" between a UART receiver
// and a UART transmitter. The result goes out as decimal ASCII followed by a
// space. A parse error, or a division by zero, produces "E ".
// Handshake: an rx byte is consumed only when rx_valid=1 and busy=0. A tx
// byte transfers on a rising edge with tx_valid=1 and tx_ready=1.
// tx_data/tx_valid hold while tx_ready=0.
module calc_core #(
  parameter int MAX_DIG = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_OPA  = 3'd0,
    ST_OPB  = 3'd1,
    ST_CALC = 3'd2,
    ST_CONV = 3'd3,
    ST_SEND = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Which part of the result is currently on tx_data while in SEND.
  localparam logic [1:0] PH_SIGN = 2'd0;
  localparam logic [1:0] PH_DIG  = 2'd1;
  localparam logic [1:0] PH_TERM = 2'd2;

  state_t            state_q, state_d;
  logic [13:0]       opa_q, opa_d, opb_q, opb_d;
  logic [3:0]        cnt_q, cnt_d;     // digit count of the operand being entered
  logic [1:0]        op_q, op_d;       // 0 '+', 1 '-', 2 '*', 3 '/'
  logic [26:0]       mag_q, mag_d;     // result magnitude, consumed by CONV
  logic              neg_q, neg_d;
  logic [7:0][3:0]   dig_q, dig_d;     // result digits, least significant first
  logic [2:0]        widx_q, widx_d;   // next digit slot written by CONV
  logic [2:0]        ptr_q, ptr_d;     // digit slot currently being sent
  logic [1:0]        phase_q, phase_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              take, xfer, is_digit, is_op, go_err, go_clear;
  logic [1:0]        op_code;
  logic signed [27:0] res;
  logic [26:0]       quo;
  logic [3:0]        rem;

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // State register: every register loads its next value; reset forces idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_OPA;
      opa_q      <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      dig_q      <= '0;
      widx_q     <= '0;
      ptr_q      <= '0;
      phase_q    <= PH_SIGN;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      mag_q      <= mag_d;
      neg_q      <= neg_d;
      dig_q      <= dig_d;
      widx_q     <= widx_d;
      ptr_q      <= ptr_d;
      phase_q    <= phase_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: parse, compute, convert, send; error/clear applied last.
  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    mag_d      = mag_q;
    neg_d      = neg_q;
    dig_d      = dig_q;
    widx_d     = widx_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    go_err     = 1'b0;
    go_clear   = 1'b0;

    take     = rx_valid && !busy_q;
    xfer     = tx_valid_q && tx_ready;
    is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) ||
               (rx_data == 8'h2A) || (rx_data == 8'h2F);
    case (rx_data)
      8'h2D:   op_code = 2'd1;
      8'h2A:   op_code = 2'd2;
      8'h2F:   op_code = 2'd3;
      default: op_code = 2'd0;
    endcase

    case (op_q)
      2'd0:    res = signed'(28'(opa_q) + 28'(opb_q));
      2'd1:    res = signed'(28'(opa_q) - 28'(opb_q));
      2'd2:    res = signed'(28'(opa_q) * 28'(opb_q));
      default: res = signed'(28'(opa_q / opb_q));
    endcase

    quo = mag_q / 27'd10;
    rem = 4'(mag_q - quo * 27'd10);

    case (state_q)
      ST_OPA: begin
        if (take) begin
          if (rx_data == 8'h20) begin
            // spaces are ignored
          end else if (is_digit) begin
            if (cnt_q == 4'(MAX_DIG)) go_err = 1'b1;
            else begin
              opa_d = opa_q * 14'd10 + {10'd0, rx_data[3:0]};
              cnt_d = cnt_q + 4'd1;
            end
          end else if (is_op) begin
            if (cnt_q == 4'd0) go_err = 1'b1;
            else begin
              op_d    = op_code;
              cnt_d   = 4'd0;
              state_d = ST_OPB;
            end
          end else if (rx_data == 8'h49) go_clear = 1'b1;
          else go_err = 1'b1;
        end
      end
      ST_OPB: begin
        if (take) begin
          if (rx_data == 8'h20) begin
            // spaces are ignored
          end else if (is_digit) begin
            if (cnt_q == 4'(MAX_DIG)) go_err = 1'b1;
            else begin
              opb_d = opb_q * 14'd10 + {10'd0, rx_data[3:0]};
              cnt_d = cnt_q + 4'd1;
            end
          end else if (rx_data == 8'h3D && cnt_q != 4'd0) begin
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end else if (rx_data == 8'h49) go_clear = 1'b1;
          else go_err = 1'b1;
        end
      end
      ST_CALC: begin
        if (op_q == 2'd3 && opb_q == 14'd0) go_err = 1'b1;
        else begin
          neg_d   = res[27];
          mag_d   = res[27] ? 27'(-res) : res[26:0];
          widx_d  = 3'd0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        // One decimal digit per cycle; stop once the remaining value fits one digit.
        dig_d[widx_q] = rem;
        mag_d         = quo;
        widx_d        = widx_q + 3'd1;
        if (mag_q < 27'd10) begin
          state_d    = ST_SEND;
          ptr_d      = widx_q;
          tx_valid_d = 1'b1;
          if (neg_q) begin
            tx_data_d = 8'h2D;
            phase_d   = PH_SIGN;
          end else begin
            tx_data_d = {4'h3, rem};
            phase_d   = PH_DIG;
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
          case (phase_q)
            PH_SIGN: begin
              tx_data_d = {4'h3, dig_q[ptr_q]};
              phase_d   = PH_DIG;
            end
            PH_DIG: begin
              if (ptr_q == 3'd0) begin
                tx_data_d = 8'h20;
                phase_d   = PH_TERM;
              end else begin
                ptr_d     = ptr_q - 3'd1;
                tx_data_d = {4'h3, dig_q[ptr_q - 3'd1]};
              end
            end
            default: go_clear = 1'b1;
          endcase
        end
      end
      ST_ERR: begin
        if (xfer) begin
          if (tx_data_q == 8'h45) tx_data_d = 8'h20;
          else go_clear = 1'b1;
        end
      end
      default: go_clear = 1'b1;
    endcase

    if (go_clear) begin
      state_d    = ST_OPA;
      opa_d      = '0;
      opb_d      = '0;
      cnt_d      = '0;
      op_d       = '0;
      tx_data_d  = 8'h00;
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
    end
    if (go_err) begin
      state_d    = ST_ERR;
      err_d      = 1'b1;
      busy_d     = 1'b1;
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h45;
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed expression vectors against hand-computed ASCII replies.
module tb_calc_core;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       err;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  calc_core #(.MAX_DIG(4)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // capture transferred bytes and err pulses between edges
  always @(negedge clk) begin
    if (n_rst) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (err) err_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk); #1;
      rx_data  = s[i];
      rx_valid = 1'b1;
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_q.size() < n && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_bytes(input string tag, input string exp_s);
    logic [31:0] g;
    for (int i = 0; i < exp_s.len(); i++) exp_q.push_back(exp_s[i]);
    check_eq({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (got_q.size() > 0) g = {24'd0, got_q.pop_front()};
      else g = 32'hFFFF_FFFF;
      check_eq($sformatf("%s byte%0d", tag, i), g, {24'd0, exp_q.pop_front()});
    end
    got_q.delete();
  endtask

  task automatic run_expr(input string tag, input string s, input string exp_s, input int exp_err);
    got_q.delete();
    err_cnt = 0;
    send_str(s);
    wait_out(exp_s.len());
    check_bytes(tag, exp_s);
    check_eq({tag, " err"}, err_cnt, exp_err);
    check_eq({tag, " busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, " state"}, {29'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int t;
    logic stable;

    // reset state
    #12;
    check_eq("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("rst busy", {31'd0, busy}, 32'd0);
    check_eq("rst err", {31'd0, err}, 32'd0);
    check_eq("rst state", {29'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // main function
    run_expr("add", "12+34=", "46 ", 0);
    run_expr("sub_sp", "5 - 12 =", "-7 ", 0);
    run_expr("mul_max", "9999*9999=", "99980001 ", 0);
    run_expr("div", "7/2=", "3 ", 0);

    // error cases, each followed by a good expression
    run_expr("div0", "7/0=", "E ", 1);
    run_expr("after_div0", "1+2=", "3 ", 0);
    run_expr("op_first", "+5=", "E ", 1);
    run_expr("zero", "6-6=", "0 ", 0);
    run_expr("five_dig", "12345", "E ", 1);
    run_expr("after_5dig", "42/5=", "8 ", 0);
    run_expr("no_opb", "3+=", "E ", 1);
    run_expr("clear_i", "12I3+4=", "7 ", 0);

    // backpressure: tx_ready low for 20 cycles after the first tx_valid
    got_q.delete();
    err_cnt = 0;
    tx_ready = 1'b0;
    send_str("8*8=");
    t = 0;
    while (!tx_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("bp tx_valid", {31'd0, tx_valid}, 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h36) stable = 1'b0;
    end
    check_eq("bp hold", {31'd0, stable}, 32'd1);
    check_eq("bp none sent", got_q.size(), 32'd0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_out(3);
    check_bytes("bp", "64 ");
    check_eq("bp err", err_cnt, 32'd0);

    // reset while sending "100 "
    got_q.delete();
    send_str("100+0=");
    t = 0;
    while (got_q.size() < 1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("mid first byte", {24'd0, got_q.size() > 0 ? got_q[0] : 8'hFF}, 32'h31);
    #1;
    n_rst = 1'b0;
    #1;
    check_eq("mid rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("mid rst tx_data", {24'd0, tx_data}, 32'd0);
    check_eq("mid rst busy", {31'd0, busy}, 32'd0);
    check_eq("mid rst err", {31'd0, err}, 32'd0);
    check_eq("mid rst state", {29'd0, dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    check_eq("mid rst hold", {31'd0, tx_valid | busy}, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    got_q.delete();
    repeat (6) @(posedge clk);
    #1;
    check_eq("no resume", got_q.size(), 32'd0);
    run_expr("post_rst", "1+1=", "2 ", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
